interrupt_request_arbiter: RTL
==============================

Name: interrupt_request_arbiter

Overview:
- Collects up to 16 asynchronous interrupt request lines (keyboard, serial, timer, ...).
- Latches rising edges as pending, applies a software-writable mask and fixed priority, then presents one interrupt index plus a request signal to the interrupt handler stage.
- Holds the request until the handler reports it is busy, then waits for the handler to finish before arbitrating again.
- Sits directly upstream of the interrupt handler, which turns index+signal into the injected instruction sequence.

Parameters:
- NUM_SOURCES, 4, number of request lines, 1..16.
- INDEX_BASE, 0, value added to the winning bit position to form the 4-bit index. NUM_SOURCES-1+INDEX_BASE must be <= 15.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- irqLines  input  NUM_SOURCES  raw asynchronous request lines, active-high, edge-triggered.
- maskWriteEnable  input  1  load maskData into the mask register.
- maskData  input  NUM_SOURCES  new mask; 1 = source enabled.
- handlerBusy  input  1  high while the handler is inside an interrupt (the handler's signal output).
- interruptIndexOut  output  4  index of the granted source; 0 when idle.
- interruptSignalOut  output  1  request to the handler; high only in REQUEST.
- pendingOut  output  NUM_SOURCES  current pending register, for debug/status.

Behaviour:
- Reset (async, reset=0): synchronizer stages, edge history, pending, state=IDLE, interruptIndexOut=0, interruptSignalOut=0 all cleared. Mask resets to all-ones.
- Reset mid-operation: everything is dropped immediately; pending requests are lost.
- Synchronizer: two flops per line (s1, s2), plus history flop s3. Edge = s2 & ~s3.
- Latency: a line first sampled high at posedge k gives s2=1 after k+1. The pending bit is set at k+2. interruptSignalOut rises at k+3 when IDLE and unmasked.
- Pending set/clear: a bit sets on edge. It clears when its request is accepted. If a set and a clear hit the same bit in one cycle, the set wins and the bit stays pending.
- Masking: masked bits still latch pending but are not eligible. A mask write takes effect on the next cycle's arbitration.
- Priority: lowest eligible bit position wins. Eligible = pending & mask.
- States:
  - IDLE: if eligible != 0, latch the winner into interruptIndexOut (winner+INDEX_BASE) and the winner bit position, then go to REQUEST. Otherwise interruptIndexOut=0.
  - REQUEST: interruptSignalOut=1; index is held stable and never re-arbitrated. When handlerBusy=1 is sampled: clear the winner's pending bit, deassert signal, go to WAIT_DONE.
  - WAIT_DONE: signal=0, index held. When handlerBusy=0 is sampled: index becomes 0, go to IDLE. The next arbitration happens in the following IDLE cycle.
- Masking the granted source while in REQUEST does not withdraw the request.
- Minimum spacing between two grants: one IDLE cycle after the handler drops busy.
- Repeated edges on a line that is already pending merge into one request (no counting).
- handlerBusy high while IDLE is ignored; no state change.

Decomposition:
- Shared package/header: state encodings (IDLE, REQUEST, WAIT_DONE), index width constant (4), default mask constant.
- One natural sub-module: irq_edge_synchronizer, handling the 2-flop sync, history flop and edge output per line, instantiated once with vector width NUM_SOURCES.
- The priority encoder stays inline as a function.

Test Plan:
- Reset, then a single pulse on irqLines[2] (NUM_SOURCES=4, INDEX_BASE=0) -> signal rises 3 cycles after the first sampling edge with index=2. Handler busy 10 cycles -> signal falls on the busy sample and index returns to 0 one cycle after busy falls; pendingOut=0000.
- Pulses on lines 3 and 1 in the same cycle -> index=1 granted first; after that handler cycle completes, index=3 granted. Exactly two grants.
- maskData=1011 written, pulse on line 2 -> pendingOut=0100, no signal. Then write mask 1111 -> signal with index=2 one cycle later.
- While WAIT_DONE serves line 0, a new edge on line 0 -> pending bit 0 re-set. A second grant with index=0 follows after busy drops.
- Same-cycle edge on line 1 and acceptance of line 1 -> pendingOut bit 1 remains 1.
- Assert reset during REQUEST with pendingOut=0110 -> interruptSignalOut=0, index=0, pendingOut=0, mask=1111 immediately. No grant after release until a new edge arrives.

Source files
------------

// File: rtl/interrupt_request_arbiter_pkg.sv
// Shared types and constants for the interrupt request arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package interrupt_request_arbiter_pkg;

    // Width of the index handed to the interrupt handler stage.
    localparam int IRQ_IDX_W = 4;

    // Out of reset every source is enabled.
    localparam logic [15:0] DEFAULT_MASK = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQUEST   = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/interrupt_request_arbiter_if.sv
// Handshake between the arbiter and the downstream interrupt handler.
// Latency: none (wires only).
// Backpressure: handlerBusy from the handler acknowledges and holds off new grants.
interface interrupt_request_arbiter_if;
    import interrupt_request_arbiter_pkg::*;

    logic [IRQ_IDX_W-1:0] interruptIndexOut;
    logic                 interruptSignalOut;
    logic                 handlerBusy;

    // Arbiter side.
    modport master (
        output interruptIndexOut,
        output interruptSignalOut,
        input  handlerBusy
    );

    // Handler side.
    modport slave (
        input  interruptIndexOut,
        input  interruptSignalOut,
        output handlerBusy
    );
endinterface

// File: rtl/interrupt_request_arbiter_irq_edge_synchronizer.sv
// Two-flop synchronizer plus history flop per line; emits a one-cycle rising-edge pulse.
// Latency: line sampled high at edge k -> edge output high during the cycle after k+1.
// Backpressure: none; free-running.
module irq_edge_synchronizer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] lines_i,
    output logic [WIDTH-1:0] edge_o
);
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] s3_q;

    // Metastability chain (s1, s2) followed by the edge-history flop (s3).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= lines_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q & ~s3_q;
endmodule

// File: rtl/interrupt_request_arbiter.sv
// Latches interrupt edges as pending, masks, picks the lowest eligible source and hands it off.
// Latency: sampled line edge k -> pending at k+2 -> interruptSignalOut at k+3 (idle, unmasked).
// Backpressure: request held until handlerBusy seen, then no new grant until busy drops.
module interrupt_request_arbiter
    import interrupt_request_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int INDEX_BASE  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irqLines,
    input  logic                   maskWriteEnable,
    input  logic [NUM_SOURCES-1:0] maskData,
    output logic [NUM_SOURCES-1:0] pendingOut,
    interrupt_request_arbiter_if.master hif
);
    arb_state_t             state_q, state_d;
    logic [NUM_SOURCES-1:0] pend_q, pend_d;
    logic [NUM_SOURCES-1:0] mask_q;
    logic [IRQ_IDX_W-1:0]   index_q, index_d;
    logic [IRQ_IDX_W-1:0]   win_q, win_d;
    logic [NUM_SOURCES-1:0] edge_s;
    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] clr;
    logic                   accept;

    // Lowest set bit position wins; scanning downward leaves the lowest one last.
    function automatic logic [IRQ_IDX_W-1:0] lowest_set(input logic [NUM_SOURCES-1:0] v);
        lowest_set = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IRQ_IDX_W'(i);
        end
    endfunction

    irq_edge_synchronizer #(.WIDTH(NUM_SOURCES)) u_sync (
        .clock   (clock),
        .reset   (reset),
        .lines_i (irqLines),
        .edge_o  (edge_s)
    );

    assign eligible = pend_q & mask_q;
    assign accept   = (state_q == ST_REQUEST) && hif.handlerBusy;

    // Clear only the accepted source; a fresh edge in the same cycle wins over the clear.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            clr[i] = accept && (win_q == IRQ_IDX_W'(i));
        end
        pend_d = (pend_q & ~clr) | edge_s;
    end

    // Pending and mask registers; mask changes are seen by the next arbitration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            mask_q <= DEFAULT_MASK[NUM_SOURCES-1:0];
        end else begin
            pend_q <= pend_d;
            if (maskWriteEnable) mask_q <= maskData;
        end
    end

    // State register together with the latched index and winner position.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            win_q   <= win_d;
        end
    end

    // Next-state: grant from IDLE, accept on busy, return on busy release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (eligible != '0)       state_d = ST_REQUEST;
            ST_REQUEST:   if (hif.handlerBusy)      state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!hif.handlerBusy)     state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // Outputs: signal is a pure state decode; index/winner only move on grant or completion.
    always_comb begin
        hif.interruptSignalOut = (state_q == ST_REQUEST);
        index_d                = index_q;
        win_d                  = win_q;
        case (state_q)
            ST_IDLE: begin
                if (eligible != '0) begin
                    win_d   = lowest_set(eligible);
                    index_d = lowest_set(eligible) + IRQ_IDX_W'(INDEX_BASE);
                end else begin
                    index_d = '0;
                end
            end
            ST_WAIT_DONE: if (!hif.handlerBusy) index_d = '0;
            default: ;
        endcase
    end

    assign hif.interruptIndexOut = index_q;
    assign pendingOut            = pend_q;
endmodule
